// File: rtl/qeciphy_pkg.sv
// Shared types, constants and helpers for the QECIPHY AXIS built-in self test.
package qeciphy_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_LINK = 2'd1,
        S_RUN       = 2'd2,
        S_DONE      = 2'd3
    } bist_state_e;

    typedef enum logic [1:0] {
        STATUS_OK        = 2'd0,
        STATUS_MISMATCH  = 2'd1,
        STATUS_TIMEOUT   = 2'd2,
        STATUS_LINK_LOST = 2'd3
    } bist_status_e;

    // Fibonacci taps for x^32 + x^22 + x^2 + x + 1 (x^k maps to state bit k-1).
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Data path is built from 32-bit lanes.
    localparam int LANE_W = 32;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic bit data_w_ok(input int w);
        return (w >= LANE_W) && ((w % LANE_W) == 0);
    endfunction

endpackage

// File: rtl/qeciphy_axis_bist_if.sv
// AXI-Stream bundle used for both the TX source and the RX sink of the BIST.
interface qeciphy_axis_bist_if #(
    parameter int DATA_W = 64
) ();

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/qeciphy_bist_pattern.sv
// Test pattern generator: counter words or 32-bit-lane PRBS words, one step per advance.
module qeciphy_bist_pattern
    import qeciphy_pkg::*;
#(
    parameter int          DATA_W = 64,
    parameter int          IDX_W  = 12,
    parameter logic [31:0] SEED   = 32'hACE1_2024
) (
    input  logic              aclk,
    input  logic              arstn,
    input  logic              mode,
    input  logic              load,
    input  logic              advance,
    output logic [DATA_W-1:0] word
);

    localparam int LANES = DATA_W / LANE_W;

    logic [IDX_W-1:0] cnt;
    logic [31:0]      lfsr;

    // Word index and LFSR state move together so both patterns stay aligned to the beat number.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            cnt  <= '0;
            lfsr <= SEED;
        end else if (load) begin
            cnt  <= '0;
            lfsr <= SEED;
        end else if (advance) begin
            cnt  <= cnt + 1'b1;
            lfsr <= lfsr_next(lfsr);
        end
    end

    // Counter words are zero-extended; PRBS lanes carry the shared state XORed with the lane number.
    always_comb begin
        word = '0;
        if (mode) begin
            for (int l = 0; l < LANES; l++) begin
                word[LANE_W*l +: LANE_W] = lfsr ^ 32'(l);
            end
        end else begin
            word = DATA_W'(cnt);
        end
    end

endmodule

// File: rtl/qeciphy_axis_bist.sv
// AXIS loopback BIST: streams a known pattern to PHY TX and checks what returns on PHY RX.
module qeciphy_axis_bist
    import qeciphy_pkg::*;
#(
    parameter int          DATA_W         = 64,
    parameter int          SEQ_LEN        = 2048,
    parameter int          TIMEOUT_CYCLES = 131072,
    parameter logic [31:0] SEED           = 32'hACE1_2024,
    localparam int         IDX_W          = $clog2(SEQ_LEN + 1)
) (
    input  logic                aclk,
    input  logic                arstn,
    input  logic                start,
    input  logic                mode,
    input  logic                link_ready,
    qeciphy_axis_bist_if.master tx,
    qeciphy_axis_bist_if.slave  rx,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [1:0]          status_code,
    output logic [15:0]         err_cnt,
    output logic [15:0]         extra_cnt,
    output logic [IDX_W-1:0]    first_err_idx
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] SEQ_IDX  = IDX_W'(SEQ_LEN);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    if (!data_w_ok(DATA_W) || SEQ_LEN < 1 || SEED == 32'd0) begin : g_bad_params
        $error("qeciphy_axis_bist: illegal DATA_W, SEQ_LEN or SEED");
    end

    bist_state_e       state, state_nxt;
    bist_status_e      status_q, status_nxt;
    logic              mode_q;
    logic [IDX_W-1:0]  tx_idx, rx_idx, tx_idx_nxt, rx_idx_nxt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [DATA_W-1:0] tx_word, exp_word;
    logic              in_run, start_ok, tx_hs, rx_hs, rx_check, rx_extra, rx_mis;

    assign in_run     = (state == S_RUN);
    assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
    assign tx.tvalid  = in_run && (tx_idx != SEQ_IDX);
    assign tx.tdata   = tx_word;
    assign rx.tready  = arstn;
    assign tx_hs      = tx.tvalid && tx.tready;
    assign rx_hs      = rx.tvalid && rx.tready;
    assign rx_check   = rx_hs && in_run && (rx_idx != SEQ_IDX);
    assign rx_extra   = rx_hs && !rx_check;
    assign rx_mis     = rx_check && (rx.tdata != exp_word);
    assign tx_idx_nxt = tx_idx + IDX_W'(tx_hs);
    assign rx_idx_nxt = rx_idx + IDX_W'(rx_check);

    assign busy        = (state == S_WAIT_LINK) || in_run;
    assign done        = (state == S_DONE);
    assign status_code = status_q;
    assign pass        = done && (status_q == STATUS_OK) && (extra_cnt == 16'd0);

    qeciphy_bist_pattern #(.DATA_W(DATA_W), .IDX_W(IDX_W), .SEED(SEED)) u_tx_pattern (
        .aclk(aclk), .arstn(arstn), .mode(mode_q), .load(start_ok), .advance(tx_hs), .word(tx_word)
    );

    qeciphy_bist_pattern #(.DATA_W(DATA_W), .IDX_W(IDX_W), .SEED(SEED)) u_rx_pattern (
        .aclk(aclk), .arstn(arstn), .mode(mode_q), .load(start_ok), .advance(rx_check), .word(exp_word)
    );

    // State and result registers.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state    <= S_IDLE;
            status_q <= STATUS_OK;
        end else begin
            state    <= state_nxt;
            status_q <= status_nxt;
        end
    end

    // Next state; a run exit uses post-handshake indices and prefers completion, then link loss, then timeout.
    always_comb begin
        state_nxt  = state;
        status_nxt = status_q;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nxt = S_WAIT_LINK;
            end
            S_WAIT_LINK: begin
                if (link_ready) state_nxt = S_RUN;
            end
            S_RUN: begin
                if ((tx_idx_nxt == SEQ_IDX) && (rx_idx_nxt == SEQ_IDX)) begin
                    state_nxt  = S_DONE;
                    status_nxt = ((err_cnt != 16'd0) || rx_mis) ? STATUS_MISMATCH : STATUS_OK;
                end else if (!link_ready) begin
                    state_nxt  = S_DONE;
                    status_nxt = STATUS_LINK_LOST;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt  = S_DONE;
                    status_nxt = STATUS_TIMEOUT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Beat indices, timeout counter and error bookkeeping; a new start wipes the previous run.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            mode_q        <= 1'b0;
            tx_idx        <= '0;
            rx_idx        <= '0;
            tmo_cnt       <= '0;
            err_cnt       <= '0;
            extra_cnt     <= '0;
            first_err_idx <= '1;
        end else if (start_ok) begin
            mode_q        <= mode;
            tx_idx        <= '0;
            rx_idx        <= '0;
            tmo_cnt       <= '0;
            err_cnt       <= '0;
            extra_cnt     <= '0;
            first_err_idx <= '1;
        end else begin
            tx_idx <= tx_idx_nxt;
            rx_idx <= rx_idx_nxt;
            if (in_run) tmo_cnt <= tmo_cnt + 1'b1;
            if (rx_mis) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                if (first_err_idx == '1) first_err_idx <= rx_idx;
            end
            if (rx_extra && (extra_cnt != 16'hFFFF)) extra_cnt <= extra_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_qeciphy_axis_bist.sv
// Self-checking bench for qeciphy_axis_bist with a queue-based loopback and a pattern reference model.
module tb_qeciphy_axis_bist;

    localparam int          DATA_W         = 64;
    localparam int          SEQ_LEN        = 640;
    localparam int          TIMEOUT_CYCLES = 3000;
    localparam logic [31:0] SEED           = 32'hACE1_2024;
    localparam int          IDX_W          = $clog2(SEQ_LEN + 1);
    localparam int          LANES          = DATA_W / 32;

    logic                aclk = 1'b0;
    logic                arstn, start, mode, link_ready;
    logic                busy, done, pass;
    logic [1:0]          status_code;
    logic [15:0]         err_cnt, extra_cnt;
    logic [IDX_W-1:0]    first_err_idx;

    qeciphy_axis_bist_if #(.DATA_W(DATA_W)) tx_if ();
    qeciphy_axis_bist_if #(.DATA_W(DATA_W)) rx_if ();

    qeciphy_axis_bist #(
        .DATA_W(DATA_W), .SEQ_LEN(SEQ_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .SEED(SEED)
    ) dut (
        .aclk(aclk), .arstn(arstn), .start(start), .mode(mode), .link_ready(link_ready),
        .tx(tx_if), .rx(rx_if), .busy(busy), .done(done), .pass(pass),
        .status_code(status_code), .err_cnt(err_cnt), .extra_cnt(extra_cnt),
        .first_err_idx(first_err_idx)
    );

    always #5 aclk = ~aclk;

    int                checks = 0;
    int                errors = 0;
    logic [31:0]       prbs_state [SEQ_LEN];
    logic [DATA_W-1:0] fifo [$];
    int                tx_beats, stall_pct, flip_idx, stop_after, drop_at, stray_req, busy_cycles;
    bit                run_mode, loop_en, link_up, rx_src_fifo, hold_valid, aborted, finished;
    logic [DATA_W-1:0] first_word, hold_data;

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                               input logic [DATA_W-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected word k: counter value, or the k-th LFSR state replicated per lane with the lane number.
    function automatic logic [DATA_W-1:0] model_word(input bit m, input int k);
        logic [DATA_W-1:0] w;
        w = '0;
        if (!m) w = DATA_W'(k);
        else for (int l = 0; l < LANES; l++) w[32*l +: 32] = prbs_state[k] ^ 32'(l);
        return w;
    endfunction

    // Records TX beats into the loopback queue (optionally corrupting one) and retires delivered RX beats.
    always @(posedge aclk) begin
        if (arstn) begin
            if (hold_valid) checkOutput("tx_hold", tx_if.tdata, hold_data);
            hold_valid = tx_if.tvalid && !tx_if.tready;
            hold_data  = tx_if.tdata;
            if (tx_if.tvalid && tx_if.tready) begin
                if (tx_beats < SEQ_LEN) checkOutput("tx_word", tx_if.tdata, model_word(run_mode, tx_beats));
                else checkOutput("tx_overrun", DATA_W'(tx_beats), DATA_W'(SEQ_LEN));
                if (tx_beats == 0) first_word = tx_if.tdata;
                fifo.push_back((tx_beats == flip_idx) ? (tx_if.tdata ^ DATA_W'(32)) : tx_if.tdata);
                tx_beats++;
            end
            if (rx_if.tvalid && rx_if.tready && rx_src_fifo && fifo.size() > 0) void'(fifo.pop_front());
        end else begin
            hold_valid = 1'b0;
        end
    end

    // Drives the PHY-side inputs away from the active edge: ready stalls, link state, RX loopback or stray beats.
    always @(negedge aclk) begin
        link_ready = link_up && !(drop_at >= 0 && tx_beats >= drop_at);
        if (!arstn) begin
            tx_if.tready = 1'b0;
            rx_if.tvalid = 1'b0;
            rx_if.tdata  = '0;
            rx_src_fifo  = 1'b0;
        end else if (stray_req > 0) begin
            rx_if.tvalid = 1'b1;
            rx_if.tdata  = DATA_W'({$urandom, $urandom});
            rx_src_fifo  = 1'b0;
            stray_req--;
        end else begin
            tx_if.tready = !(stop_after >= 0 && tx_beats >= stop_after) &&
                           (int'($urandom_range(99)) >= stall_pct);
            rx_if.tvalid = loop_en && link_ready && (fifo.size() > 0);
            rx_if.tdata  = (fifo.size() > 0) ? fifo[0] : '0;
            rx_src_fifo  = rx_if.tvalid;
        end
    end

    // One BIST run: configure the loopback, pulse start and wait (bounded) for DONE or the abort point.
    task automatic applyStimulus(input bit m, input int stall, input int flip, input int stop,
                                 input int drop, input int mid_start, input int reset_at);
        bit pulsed;
        pulsed      = 1'b0;
        fifo.delete();
        tx_beats    = 0;
        run_mode    = m;
        stall_pct   = stall;
        flip_idx    = flip;
        stop_after  = stop;
        drop_at     = drop;
        loop_en     = 1'b1;
        link_up     = 1'b1;
        busy_cycles = 0;
        aborted     = 1'b0;
        finished    = 1'b0;
        first_word  = '0;
        @(negedge aclk);
        @(negedge aclk);
        start = 1'b1;
        mode  = m;
        for (int i = 0; i < 20000; i++) begin
            @(negedge aclk);
            start = 1'b0;
            if (busy) busy_cycles++;
            if (done) begin finished = 1'b1; break; end
            if (reset_at >= 0 && tx_beats >= reset_at) begin aborted = 1'b1; finished = 1'b1; break; end
            if (mid_start >= 0 && tx_beats == mid_start && !pulsed) begin
                start  = 1'b1;
                mode   = !m;
                pulsed = 1'b1;
            end
        end
        checkOutput("run_finished", DATA_W'(finished), DATA_W'(1));
        loop_en = 1'b0;
    endtask

    task automatic checkResetState();
        checkOutput("rst_tvalid", DATA_W'(tx_if.tvalid), '0);
        checkOutput("rst_tready", DATA_W'(rx_if.tready), '0);
        checkOutput("rst_busy", DATA_W'(busy), '0);
        checkOutput("rst_done", DATA_W'(done), '0);
        checkOutput("rst_pass", DATA_W'(pass), '0);
        checkOutput("rst_status", DATA_W'(status_code), '0);
        checkOutput("rst_err", DATA_W'(err_cnt), '0);
        checkOutput("rst_extra", DATA_W'(extra_cnt), '0);
        checkOutput("rst_first", DATA_W'(first_err_idx), DATA_W'({IDX_W{1'b1}}));
        checkOutput("rst_tdata", tx_if.tdata, '0);
    endtask

    initial begin
        logic [31:0] s;
        s = SEED;
        for (int k = 0; k < SEQ_LEN; k++) begin
            prbs_state[k] = s;
            s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
        end
        arstn = 1'b0; start = 1'b0; mode = 1'b0; link_ready = 1'b0;
        link_up = 1'b0; loop_en = 1'b0; stray_req = 0; tx_beats = 0;
        stall_pct = 0; flip_idx = -1; stop_after = -1; drop_at = -1; run_mode = 1'b0;
        hold_valid = 1'b0; rx_src_fifo = 1'b0;

        repeat (3) @(negedge aclk);
        checkResetState();
        arstn = 1'b1;
        @(negedge aclk);
        checkOutput("tready_after_reset", DATA_W'(rx_if.tready), DATA_W'(1));

        $display("[TB] stray RX beat while idle");
        stray_req = 1;
        repeat (4) @(negedge aclk);
        checkOutput("idle_stray_extra", DATA_W'(extra_cnt), DATA_W'(1));

        $display("[TB] counter loopback, no stalls, ignored start mid-run");
        applyStimulus(1'b0, 0, -1, -1, -1, 300, -1);
        checkOutput("cnt_done", DATA_W'(done), DATA_W'(1));
        checkOutput("cnt_pass", DATA_W'(pass), DATA_W'(1));
        checkOutput("cnt_status", DATA_W'(status_code), DATA_W'(0));
        checkOutput("cnt_err", DATA_W'(err_cnt), '0);
        checkOutput("cnt_extra", DATA_W'(extra_cnt), '0);
        checkOutput("cnt_first", DATA_W'(first_err_idx), DATA_W'({IDX_W{1'b1}}));
        checkOutput("cnt_beats", DATA_W'(tx_beats), DATA_W'(SEQ_LEN));
        checkOutput("cnt_busy", DATA_W'(busy), '0);

        $display("[TB] stray RX beat while done");
        stray_req = 1;
        repeat (4) @(negedge aclk);
        checkOutput("done_stray_extra", DATA_W'(extra_cnt), DATA_W'(1));
        checkOutput("done_stray_pass", DATA_W'(pass), '0);
        checkOutput("done_stray_done", DATA_W'(done), DATA_W'(1));

        $display("[TB] PRBS loopback, 30 percent stalls");
        applyStimulus(1'b1, 30, -1, -1, -1, -1, -1);
        checkOutput("prbs_pass", DATA_W'(pass), DATA_W'(1));
        checkOutput("prbs_status", DATA_W'(status_code), DATA_W'(0));
        checkOutput("prbs_err", DATA_W'(err_cnt), '0);
        checkOutput("prbs_lane1", DATA_W'(first_word[63:32]), DATA_W'(SEED ^ 32'd1));
        checkOutput("prbs_lane0", DATA_W'(first_word[31:0]), DATA_W'(SEED));

        $display("[TB] PRBS loopback, beat 100 corrupted");
        applyStimulus(1'b1, 20, 100, -1, -1, -1, -1);
        checkOutput("flip_status", DATA_W'(status_code), DATA_W'(1));
        checkOutput("flip_err", DATA_W'(err_cnt), DATA_W'(1));
        checkOutput("flip_first", DATA_W'(first_err_idx), DATA_W'(100));
        checkOutput("flip_pass", DATA_W'(pass), '0);
        checkOutput("flip_extra", DATA_W'(extra_cnt), '0);

        $display("[TB] TX stalled after beat 10");
        applyStimulus(1'b0, 0, -1, 11, -1, -1, -1);
        checkOutput("tmo_status", DATA_W'(status_code), DATA_W'(2));
        checkOutput("tmo_busy_cycles", DATA_W'(busy_cycles), DATA_W'(TIMEOUT_CYCLES + 1));
        checkOutput("tmo_pass", DATA_W'(pass), '0);
        checkOutput("tmo_err", DATA_W'(err_cnt), '0);

        $display("[TB] link dropped at beat 500");
        applyStimulus(1'b1, 0, -1, -1, 500, -1, -1);
        checkOutput("link_status", DATA_W'(status_code), DATA_W'(3));
        checkOutput("link_pass", DATA_W'(pass), '0);
        checkOutput("link_extra", DATA_W'(extra_cnt), '0);

        $display("[TB] reset in the middle of a run");
        applyStimulus(1'b0, 0, 7, -1, -1, -1, 200);
        checkOutput("abort_reached", DATA_W'(aborted), DATA_W'(1));
        arstn = 1'b0;
        #1;
        checkResetState();
        repeat (2) @(negedge aclk);
        arstn = 1'b1;
        fifo.delete();
        @(negedge aclk);

        $display("[TB] clean PRBS run after reset");
        applyStimulus(1'b1, 10, -1, -1, -1, -1, -1);
        checkOutput("post_rst_pass", DATA_W'(pass), DATA_W'(1));
        checkOutput("post_rst_err", DATA_W'(err_cnt), '0);
        checkOutput("post_rst_extra", DATA_W'(extra_cnt), '0);
        checkOutput("post_rst_beats", DATA_W'(tx_beats), DATA_W'(SEQ_LEN));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
